ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline boundary that captures the ALU result and its instruction sideband once the ALU reports completion, and presents it to the memory stage over a valid/ready handshake. It holds a two-entry buffer (output register plus skid register) so that `ex_ready_o` is a pure register output and multi-cycle MUL/DIV completions are never lost under memory-stage backpressure. It also flags misaligned load/store addresses and exposes a forwarding port and an ALU-stall cycle counter.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, width of the stall-cycle counter (saturating)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop all buffered entries (branch/trap redirect)
- ex_valid_i  in  1  EX stage holds an instruction
- alu_stall_i  in  1  ALU multi-cycle operation not yet complete
- ex_ready_o  out  1  stage can accept; registered
- alu_result_i  in  XLEN  ALU result / effective address
- store_data_i  in  XLEN  rs2 value for stores
- pc_i  in  XLEN  instruction PC
- rd_addr_i  in  5  destination register
- rf_we_i  in  1  register write enable
- mem_re_i / mem_we_i  in  1 each  load / store
- mem_size_i  in  2  00 byte, 01 half, 10 word
- mem_valid_o  out  1  output entry valid
- mem_ready_i  in  1  memory stage accepts
- mem_result_o, mem_store_data_o, mem_pc_o  out  XLEN each
- mem_rd_addr_o  out  5; mem_rf_we_o, mem_re_o, mem_we_o  out  1 each; mem_size_o  out  2
- mem_misalign_o  out  1  entry's access is misaligned
- fwd_valid_o  out  1  output entry forwardable (valid, rf_we, not load)
- fwd_rd_o  out  5; fwd_data_o  out  XLEN  forwarding data = mem_result_o
- stall_cnt_o  out  CNT_W  cycles with ex_valid_i && alu_stall_i

## Operation
- Accept = ex_valid_i && !alu_stall_i && ex_ready_o && !flush_i.
- Entry capture: all inputs; rf_we forced 0 when rd_addr_i == 0; misalign = (mem_re_i|mem_we_i) && ((size==01 && addr[0]) || (size==10 && addr[1:0]!=0) || size==11).
- States (from out_valid_q, skid_valid_q): EMPTY (0,0), FULL (1,0), SKID (1,1). (0,1) is illegal.
- EMPTY: accept -> FULL (entry to output reg).
- FULL: drain only (mem_ready_i, no accept) -> EMPTY; accept with drain -> FULL (new entry replaces output); accept without drain -> SKID (new entry to skid reg).
- SKID: ex_ready_o = 0; drain -> FULL, skid moves to output reg; no drain -> hold.
- ex_ready_o registered = next-state skid_valid == 0.
- flush_i: next edge -> EMPTY regardless of accept/drain same cycle; data registers need not clear. Flush has priority.
- Output fields held stable while mem_valid_o && !mem_ready_i.
- stall_cnt_o increments each cycle ex_valid_i && alu_stall_i; saturates at all-ones; not cleared by flush.

## Timing
- Reset (async assert, sync-safe release): mem_valid_o 0, ex_ready_o 1, all data/sideband outputs 0, mem_misalign_o 0, fwd_valid_o 0, stall_cnt_o 0.
- Latency: accepted in cycle N -> mem_valid_o in cycle N+1 (EMPTY or draining FULL).
- Throughput: one entry per cycle with continuous mem_ready_i.
- ex_ready_o falls the cycle after SKID is entered; rises the cycle after the skid drains.
- Reset mid-operation: both entries discarded immediately; counter cleared.
- mem_ready_i while mem_valid_o == 0 is ignored.
- fwd_* is combinational from output registers only (no input-to-output path).

## Test plan
- Back-to-back ADD results 0x10, 0x20, 0x30 with mem_ready_i = 1 -> mem_result_o 0x10, 0x20, 0x30 on consecutive cycles, ex_ready_o stays 1.
- DIV with alu_stall_i high 33 cycles then result 0x7 -> no capture during stall, mem_valid_o one cycle after stall drops, stall_cnt_o = 33.
- mem_ready_i = 0, three accept attempts of 0xA, 0xB, 0xC -> SKID after 0xB, ex_ready_o 0, 0xC not accepted; raise mem_ready_i -> 0xA, 0xB, then 0xC delivered in order.
- Loads with mem_size 10 at 0x1002, 01 at 0x1001, 00 at 0x1003 -> misalign 1, 1, 0; fwd_valid_o 0 for all.
- Flush in SKID state with simultaneous accept and mem_ready_i -> next cycle mem_valid_o 0, ex_ready_o 1, no entry delivered.
- rd_addr_i = 0 with rf_we_i = 1 -> mem_rf_we_o 0, fwd_valid_o 0; reset asserted mid-SKID -> all outputs reset values immediately.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// Execute-to-memory pipeline boundary. An instruction is captured once the
// ALU reports completion and is presented to the memory stage over a
// valid/ready handshake. A two-entry buffer (output register + skid register)
// keeps ex_ready_o a pure register output while never dropping a completed
// result under memory-stage backpressure. Misaligned load/store accesses are
// flagged at capture, the output entry is exposed as a forwarding source, and
// cycles spent waiting on a multi-cycle ALU operation are counted.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   flush_i                  discard all buffered entries (redirect)
//   ex_valid_i, alu_stall_i  EX holds an instruction / ALU not yet done
//   ex_ready_o               stage can accept (registered)
//   alu_result_i, store_data_i, pc_i, rd_addr_i, rf_we_i,
//   mem_re_i, mem_we_i, mem_size_i      captured instruction fields
//   mem_valid_o, mem_ready_i handshake toward the memory stage
//   mem_*_o                  output entry fields, mem_misalign_o flag
//   fwd_valid_o, fwd_rd_o, fwd_data_o   forwarding from the output entry
//   stall_cnt_o              saturating count of ALU-stall cycles
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             ex_valid_i,
  input  logic             alu_stall_i,
  output logic             ex_ready_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  store_data_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rf_we_i,
  input  logic             mem_re_i,
  input  logic             mem_we_i,
  input  logic [1:0]       mem_size_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic [XLEN-1:0]  mem_result_o,
  output logic [XLEN-1:0]  mem_store_data_o,
  output logic [XLEN-1:0]  mem_pc_o,
  output logic [4:0]       mem_rd_addr_o,
  output logic             mem_rf_we_o,
  output logic             mem_re_o,
  output logic             mem_we_o,
  output logic [1:0]       mem_size_o,
  output logic             mem_misalign_o,
  output logic             fwd_valid_o,
  output logic [4:0]       fwd_rd_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            rf_we;
    logic            re;
    logic            we;
    logic [1:0]      size;
    logic            misalign;
  } entry_t;

  // State encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  function automatic logic misaligned(input logic re, input logic we,
                                      input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = ((size == 2'b01) && addr_lo[0]) ||
          ((size == 2'b10) && (addr_lo != 2'b00)) ||
          (size == 2'b11);
    return (re | we) & bad;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic             ready_q;
  entry_t           in_entry, out_q, skid_q;
  logic             accept, drain;
  logic             load_out_in, load_out_skid, load_skid;
  logic [CNT_W-1:0] cnt_q;

  assign accept = ex_valid_i && !alu_stall_i && ready_q && !flush_i;
  // mem_ready_i is only meaningful while an entry is presented.
  assign drain  = state_q[1] && mem_ready_i;

  always_comb begin
    in_entry.result     = alu_result_i;
    in_entry.store_data = store_data_i;
    in_entry.pc         = pc_i;
    in_entry.rd         = rd_addr_i;
    // Writes to x0 are dropped here so neither writeback nor forwarding sees them.
    in_entry.rf_we      = rf_we_i && (rd_addr_i != 5'd0);
    in_entry.re         = mem_re_i;
    in_entry.we         = mem_we_i;
    in_entry.size       = mem_size_i;
    in_entry.misalign   = misaligned(mem_re_i, mem_we_i, mem_size_i, alu_result_i[1:0]);
  end

  // ---- control: state register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // Ready is the registered view of "skid will be free next cycle".
      ready_q <= !state_d[0];
    end
  end

  // ---- control: next state and buffer load enables ----
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = FULL;
          load_out_in = 1'b1;
        end
      end
      FULL: begin
        if (accept && drain) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (drain) begin
          state_d       = FULL;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Redirect wins over every other transition; stale data may stay in place.
    if (flush_i) state_d = EMPTY;
  end

  // ---- output register (reset so idle outputs read as zero) ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (load_out_in) begin
      out_q <= in_entry;
    end else if (load_out_skid) begin
      out_q <= skid_q;
    end
  end

  // ---- skid register ----
  always_ff @(posedge clk_i) begin
    if (load_skid) skid_q <= in_entry;
  end

  // ---- stall-cycle counter ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (ex_valid_i && alu_stall_i) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  // ---- outputs ----
  always_comb begin
    ex_ready_o       = ready_q;
    mem_valid_o      = state_q[1];
    mem_result_o     = out_q.result;
    mem_store_data_o = out_q.store_data;
    mem_pc_o         = out_q.pc;
    mem_rd_addr_o    = out_q.rd;
    mem_rf_we_o      = out_q.rf_we;
    mem_re_o         = out_q.re;
    mem_we_o         = out_q.we;
    mem_size_o       = out_q.size;
    mem_misalign_o   = out_q.misalign;
    // Load data is not available yet, so loads are never a forwarding source.
    fwd_valid_o      = state_q[1] && out_q.rf_we && !out_q.re;
    fwd_rd_o         = out_q.rd;
    fwd_data_o       = out_q.result;
    stall_cnt_o      = cnt_q;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed steps with a scoreboard queue holding
// the entries expected at the memory-stage interface.
module tb_ex_mem_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk, rst_n;
  logic             flush, ex_valid, alu_stall, ex_ready;
  logic [XLEN-1:0]  alu_result, store_data, pc;
  logic [4:0]       rd_addr;
  logic             rf_we, mem_re, mem_we;
  logic [1:0]       mem_size;
  logic             mem_valid, mem_ready;
  logic [XLEN-1:0]  m_result, m_store_data, m_pc;
  logic [4:0]       m_rd;
  logic             m_rf_we, m_re, m_we, m_misalign;
  logic [1:0]       m_size;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] stall_cnt;

  ex_mem_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ex_valid_i(ex_valid), .alu_stall_i(alu_stall), .ex_ready_o(ex_ready),
    .alu_result_i(alu_result), .store_data_i(store_data), .pc_i(pc),
    .rd_addr_i(rd_addr), .rf_we_i(rf_we), .mem_re_i(mem_re), .mem_we_i(mem_we),
    .mem_size_i(mem_size), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_result_o(m_result), .mem_store_data_o(m_store_data), .mem_pc_o(m_pc),
    .mem_rd_addr_o(m_rd), .mem_rf_we_o(m_rf_we), .mem_re_o(m_re), .mem_we_o(m_we),
    .mem_size_o(m_size), .mem_misalign_o(m_misalign),
    .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] result, store_data, pc;
    logic [4:0]      rd;
    logic            rf_we, re, we, misalign;
    logic [1:0]      size;
  } exp_t;

  exp_t             q[$];
  logic             exp_ready;
  logic [CNT_W-1:0] exp_cnt;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [XLEN-1:0] res, input logic [XLEN-1:0] sd,
                        input logic [XLEN-1:0] p, input logic [4:0] rd,
                        input logic we_rf, input logic re, input logic we,
                        input logic [1:0] sz);
    alu_result = res; store_data = sd; pc = p; rd_addr = rd;
    rf_we = we_rf; mem_re = re; mem_we = we; mem_size = sz;
  endtask

  function automatic logic exp_misalign(input logic re, input logic we,
                                        input logic [1:0] sz, input logic [XLEN-1:0] a);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = a[0];
      2'b10:   r = (a[1:0] != 2'b00);
      default: r = 1'b1;
    endcase
    return (re || we) && r;
  endfunction

  // Called at a falling edge with inputs already driven: checks the DUT
  // against the model, advances the model, then moves to the next falling edge.
  task automatic cycle();
    exp_t e;
    logic acc, drn;
    #4;
    chk("mem_valid", mem_valid, q.size() > 0);
    chk("ex_ready", ex_ready, exp_ready);
    chk("stall_cnt", stall_cnt, exp_cnt);
    if (q.size() > 0) begin
      e = q[0];
      chk("result", m_result, e.result);
      chk("store_data", m_store_data, e.store_data);
      chk("pc", m_pc, e.pc);
      chk("rd", m_rd, e.rd);
      chk("rf_we", m_rf_we, e.rf_we);
      chk("re", m_re, e.re);
      chk("we", m_we, e.we);
      chk("size", m_size, e.size);
      chk("misalign", m_misalign, e.misalign);
      chk("fwd_valid", fwd_valid, e.rf_we && !e.re);
      chk("fwd_rd", fwd_rd, e.rd);
      chk("fwd_data", fwd_data, e.result);
    end else begin
      chk("fwd_valid_idle", fwd_valid, 1'b0);
    end
    acc = ex_valid && !alu_stall && exp_ready && !flush;
    drn = (q.size() > 0) && mem_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.result = alu_result; e.store_data = store_data; e.pc = pc;
        e.rd = rd_addr; e.rf_we = rf_we && (rd_addr != 5'd0);
        e.re = mem_re; e.we = mem_we; e.size = mem_size;
        e.misalign = exp_misalign(mem_re, mem_we, mem_size, alu_result);
        q.push_back(e);
      end
    end
    if (ex_valid && alu_stall && !(&exp_cnt)) exp_cnt = exp_cnt + 1;
    exp_ready = (q.size() < 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; alu_stall = 1'b0; mem_ready = 1'b0;
    set_op('0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    exp_ready = 1'b1; exp_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_result", m_result, 0);
    chk("rst_pc", m_pc, 0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;

    // Back-to-back ADD results with continuous ready.
    mem_ready = 1'b1; ex_valid = 1'b1;
    set_op(32'h10, 32'h0, 32'h100, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    set_op(32'h20, 32'h0, 32'h104, 5'd2, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    set_op(32'h30, 32'h0, 32'h108, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    ex_valid = 1'b0; cycle(); cycle();

    // Multi-cycle DIV: 33 stall cycles then the result.
    ex_valid = 1'b1; alu_stall = 1'b1;
    set_op(32'h7, 32'h0, 32'h200, 5'd4, 1'b1, 1'b0, 1'b0, 2'b10);
    repeat (33) cycle();
    alu_stall = 1'b0; cycle();
    ex_valid = 1'b0; cycle();
    chk("div_stall_cnt", stall_cnt, 33);
    cycle();

    // Backpressure: A, B fill the buffer, C must wait.
    mem_ready = 1'b0; ex_valid = 1'b1;
    set_op(32'hA, 32'h5A, 32'h300, 5'd5, 1'b1, 1'b0, 1'b1, 2'b10); cycle();
    set_op(32'hB, 32'h5B, 32'h304, 5'd6, 1'b1, 1'b0, 1'b1, 2'b10); cycle();
    set_op(32'hC, 32'h5C, 32'h308, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    chk("skid_ex_ready", ex_ready, 1'b0);
    cycle();
    mem_ready = 1'b1; cycle(); cycle();
    ex_valid = 1'b0; cycle(); cycle();

    // Loads of various sizes and alignments.
    ex_valid = 1'b1;
    set_op(32'h1002, 32'h0, 32'h400, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10); cycle();
    set_op(32'h1001, 32'h0, 32'h404, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01); cycle();
    set_op(32'h1003, 32'h0, 32'h408, 5'd10, 1'b1, 1'b1, 1'b0, 2'b00); cycle();
    set_op(32'h1004, 32'h99, 32'h40C, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11); cycle();
    ex_valid = 1'b0; cycle(); cycle();

    // Flush while in SKID with accept attempt and ready.
    mem_ready = 1'b0; ex_valid = 1'b1;
    set_op(32'h51, 32'h0, 32'h500, 5'd11, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    set_op(32'h52, 32'h0, 32'h504, 5'd12, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    set_op(32'h53, 32'h0, 32'h508, 5'd13, 1'b1, 1'b0, 1'b0, 2'b10);
    flush = 1'b1; mem_ready = 1'b1; cycle();
    flush = 1'b0; ex_valid = 1'b0;
    chk("flush_mem_valid", mem_valid, 1'b0);
    chk("flush_ex_ready", ex_ready, 1'b1);
    cycle(); cycle();

    // Write to x0 is not a register write.
    ex_valid = 1'b1;
    set_op(32'h66, 32'h0, 32'h600, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    ex_valid = 1'b0; cycle();

    // Reset asserted while in SKID.
    mem_ready = 1'b0; ex_valid = 1'b1;
    set_op(32'h71, 32'h0, 32'h700, 5'd14, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    set_op(32'h72, 32'h0, 32'h704, 5'd15, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    ex_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_valid", mem_valid, 1'b0);
    chk("rst_mid_ex_ready", ex_ready, 1'b1);
    chk("rst_mid_result", m_result, 0);
    chk("rst_mid_pc", m_pc, 0);
    chk("rst_mid_rf_we", m_rf_we, 1'b0);
    chk("rst_mid_fwd_valid", fwd_valid, 1'b0);
    chk("rst_mid_stall_cnt", stall_cnt, 0);
    q.delete(); exp_cnt = '0; exp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1; cycle();
    ex_valid = 1'b1;
    set_op(32'h81, 32'h0, 32'h800, 5'd16, 1'b1, 1'b0, 1'b0, 2'b10); cycle();
    ex_valid = 1'b0; cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
